rtc_alarm_timer: RTL and testbench
==================================

# rtc_alarm_timer

Parametrised real-time clock keeping hours/minutes/seconds from a configurable input clock frequency, with NUM_ALARMS programmable hour:minute alarms and a CPU register port for setting time, arming alarms and reading state back. Sits on the CPU peripheral bus next to the other memory-mapped blocks and drives the time display plus a level alarm interrupt into the interrupt controller.

## Interface
- CLK_FREQ, 10000000: input clock frequency in Hz; one second = CLK_FREQ cycles (>= 2).
- NUM_ALARMS, 2: number of alarm channels, legal range 1..4.
- clock  input  1  system clock.
- rst_n  input  1  reset: asynchronous, active-low; clock clock.
- w_en_n  input  1  CPU write enable, active-low, one write per low cycle.
- r_en_n  input  1  CPU read enable, active-low.
- addr  input  16  register address; only addr[3:0] decoded.
- wdata  input  8  write data.
- rdata  output  8  registered read data.
- hour  output  6  current hour, 0..23.
- minute  output  6  current minute, 0..59.
- second  output  6  current second, 0..59.
- sec_tick  output  1  one-cycle pulse on every second increment.
- alarm_irq  output  NUM_ALARMS  per-channel level interrupt = status & enable.

## Operation
- Register map (addr[3:0]): 0x0+2n alarm n hour, 0x1+2n alarm n minute (n < NUM_ALARMS); 0x8 hour; 0x9 minute; 0xA second; 0xB alarm enable mask; 0xC alarm status (read; write 1 to clear); 0xD control, bit0 = run.
- Write value checks: hour/alarm-hour > 23 or minute/second/alarm-minute > 59 → write ignored, register unchanged. Only low 6 bits used; enable/status use low NUM_ALARMS bits. Writes to unmapped or absent-alarm addresses ignored.
- Writing second (0xA) also clears the prescaler, so the next tick is exactly CLK_FREQ cycles later.
- Prescaler counts 0..CLK_FREQ-1 while run=1; holds when run=0. Wrap produces sec_tick.
- On tick: second+1; 59→0 carries minute; minute 59→0 carries hour; 23:59:59 → 00:00:00.
- Alarm n fires when the tick lands on second=0 with hour==alarm hour and minute==alarm minute and enable[n]=1: status[n] set. Setting the time directly to a matching value does not fire.
- Status is sticky until cleared by write-1 to 0xC. Clear and set on same cycle: set wins.
- Clearing enable[n] masks alarm_irq[n] but keeps status[n].
- Reads of unmapped or absent-alarm addresses return 0.

## Timing
- Reset: hour/minute/second 0, prescaler 0, run 1, all alarm registers 0, enable 0, status 0, rdata 0, sec_tick 0, alarm_irq 0.
- Time fields and sec_tick update on the clock edge where the prescaler wraps; status set on the same edge; alarm_irq follows one cycle later (registered from status & enable).
- CPU write to 0x8/0x9/0xA on the same cycle as a tick: write wins, the tick's increments to all time fields are discarded that cycle (sec_tick still pulses).
- Read: rdata valid the cycle after r_en_n low; holds last value when r_en_n high. Read and write to same address same cycle returns pre-write value.
- Reset asserted mid-second discards the partial prescaler count.

## Structure
- Shared package rtc_pkg: register address constants, HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59, field width 6.
- Sub-module rtc_prescaler: parametrised by CLK_FREQ, inputs run and clear, output tick; counter width $clog2(CLK_FREQ).
- Time counters, alarm compare, register file and read mux in the top module.

## Test plan
- CLK_FREQ=4, reset then run 240 cycles -> second=59 at cycle 236, minute=1 second=0 after 240 cycles; sec_tick every 4th cycle.
- Write hour=23, minute=59, second=59, wait 4 cycles -> 00:00:00, sec_tick high one cycle.
- Write hour=24, minute=60 -> read back still previous values; write hour=12 -> read 0x0C next cycle.
- Alarm 1 = 01:00, enable=0x2, time 00:59:59, one tick -> status=0x2, alarm_irq=0b10 next cycle; write 0x2 to 0xC -> alarm_irq=0.
- Write second=30 on the same cycle as a tick -> second=30, minute unchanged; next tick exactly 4 cycles later.
- Write control run=0 for 20 cycles -> time and prescaler frozen, no sec_tick; assert rst_n low mid-second -> all outputs reset values.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants, time record type and wrap helper for the RTC block.
package rtc_pkg;

   localparam int unsigned FIELD_W = 6;

   localparam logic [FIELD_W-1:0] HOUR_MAX = 6'd23;
   localparam logic [FIELD_W-1:0] MIN_MAX  = 6'd59;
   localparam logic [FIELD_W-1:0] SEC_MAX  = 6'd59;

   localparam logic [3:0] ADDR_HOUR   = 4'h8;
   localparam logic [3:0] ADDR_MIN    = 4'h9;
   localparam logic [3:0] ADDR_SEC    = 4'hA;
   localparam logic [3:0] ADDR_EN     = 4'hB;
   localparam logic [3:0] ADDR_STATUS = 4'hC;
   localparam logic [3:0] ADDR_CTRL   = 4'hD;

   typedef struct packed {
      logic [FIELD_W-1:0] hr;
      logic [FIELD_W-1:0] mn;
      logic [FIELD_W-1:0] sc;
   } rtc_time_t;

   // Increment a time field, wrapping to zero after its maximum.
   function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] v,
                                                   input logic [FIELD_W-1:0] max);
      return (v == max) ? '0 : v + 1'b1;
   endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides the input clock down to a one-cycle tick every CLK_FREQ cycles.
module rtc_prescaler
   import rtc_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 10000000
) (
   input  logic clock,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = $clog2(CLK_FREQ);
   localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = run && (cnt_q == LAST);

   // Next count: clear restarts the second, otherwise count while running.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   // Prescaler counter register.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rtc_alarm_timer.sv
// Real-time clock with hour:minute alarms and a CPU register port.
module rtc_alarm_timer
   import rtc_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 10000000,
   parameter int unsigned NUM_ALARMS = 2
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  w_en_n,
   input  logic                  r_en_n,
   input  logic [15:0]           addr,
   input  logic [7:0]            wdata,
   output logic [7:0]            rdata,
   output logic [5:0]            hour,
   output logic [5:0]            minute,
   output logic [5:0]            second,
   output logic                  sec_tick,
   output logic [NUM_ALARMS-1:0] alarm_irq
);

   rtc_time_t time_q, time_d, time_inc;
   logic                  run_q;
   logic [NUM_ALARMS-1:0] en_q, status_q, status_d, fire, clr;
   logic [NUM_ALARMS-1:0] irq_q;
   logic                  sec_tick_q;
   logic [7:0]            rdata_q, rdata_d;
   logic [FIELD_W-1:0]    alm_hr_q  [NUM_ALARMS];
   logic [FIELD_W-1:0]    alm_min_q [NUM_ALARMS];

   logic                  tick, wr, hr_ok, min_ok, wr_hr, wr_min, wr_sec, time_wr, carry_min;
   logic [3:0]            a;
   logic [FIELD_W-1:0]    wv;
   logic                  unused_addr_hi;

   assign a              = addr[3:0];
   assign unused_addr_hi = ^addr[15:4];
   assign wv             = wdata[FIELD_W-1:0];
   assign wr             = !w_en_n;
   assign hr_ok          = wdata <= 8'(HOUR_MAX);
   assign min_ok         = wdata <= 8'(MIN_MAX);
   assign wr_hr          = wr && (a == ADDR_HOUR) && hr_ok;
   assign wr_min         = wr && (a == ADDR_MIN)  && min_ok;
   assign wr_sec         = wr && (a == ADDR_SEC)  && min_ok;
   assign time_wr        = wr_hr || wr_min || wr_sec;
   assign clr            = (wr && (a == ADDR_STATUS)) ? wdata[NUM_ALARMS-1:0] : '0;

   rtc_prescaler #(.CLK_FREQ(CLK_FREQ)) u_prescaler (
      .clock (clock),
      .rst_n (rst_n),
      .run   (run_q),
      .clear (wr_sec),
      .tick  (tick)
   );

   // Next time value and alarm matches; a CPU time write discards the whole tick increment.
   always_comb begin
      carry_min   = (time_q.sc == SEC_MAX);
      time_inc.sc = wrap_inc(time_q.sc, SEC_MAX);
      time_inc.mn = carry_min ? wrap_inc(time_q.mn, MIN_MAX) : time_q.mn;
      time_inc.hr = (carry_min && (time_q.mn == MIN_MAX)) ? wrap_inc(time_q.hr, HOUR_MAX)
                                                           : time_q.hr;
      time_d = time_q;
      if (time_wr) begin
         if (wr_hr)  time_d.hr = wv;
         if (wr_min) time_d.mn = wv;
         if (wr_sec) time_d.sc = wv;
      end else if (tick) begin
         time_d = time_inc;
      end
      fire = '0;
      for (int unsigned n = 0; n < NUM_ALARMS; n++) begin
         fire[n] = tick && !time_wr && carry_min && en_q[n] &&
                   (alm_hr_q[n] == time_inc.hr) && (alm_min_q[n] == time_inc.mn);
      end
      status_d = (status_q & ~clr) | fire;
   end

   // Read mux over the register map; unmapped and absent alarms read as zero.
   always_comb begin
      rdata_d = '0;
      for (int unsigned n = 0; n < NUM_ALARMS; n++) begin
         if (!a[3] && (a[2:1] == 2'(n))) begin
            rdata_d = {2'b00, a[0] ? alm_min_q[n] : alm_hr_q[n]};
         end
      end
      case (a)
         ADDR_HOUR:   rdata_d = {2'b00, time_q.hr};
         ADDR_MIN:    rdata_d = {2'b00, time_q.mn};
         ADDR_SEC:    rdata_d = {2'b00, time_q.sc};
         ADDR_EN:     rdata_d = 8'(en_q);
         ADDR_STATUS: rdata_d = 8'(status_q);
         ADDR_CTRL:   rdata_d = {7'b0, run_q};
         default:     ;
      endcase
   end

   // Time, control, status, read data and registered outputs.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         time_q     <= '0;
         run_q      <= 1'b1;
         en_q       <= '0;
         status_q   <= '0;
         irq_q      <= '0;
         sec_tick_q <= 1'b0;
         rdata_q    <= '0;
      end else begin
         time_q     <= time_d;
         status_q   <= status_d;
         irq_q      <= status_q & en_q;
         sec_tick_q <= tick;
         if (wr && (a == ADDR_EN))   en_q  <= wdata[NUM_ALARMS-1:0];
         if (wr && (a == ADDR_CTRL)) run_q <= wdata[0];
         if (!r_en_n)                rdata_q <= rdata_d;
      end
   end

   // Alarm hour/minute registers with range-checked writes.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned n = 0; n < NUM_ALARMS; n++) begin
            alm_hr_q[n]  <= '0;
            alm_min_q[n] <= '0;
         end
      end else begin
         for (int unsigned n = 0; n < NUM_ALARMS; n++) begin
            if (wr && !a[3] && (a[2:1] == 2'(n))) begin
               if (!a[0] && hr_ok)  alm_hr_q[n]  <= wv;
               if (a[0]  && min_ok) alm_min_q[n] <= wv;
            end
         end
      end
   end

   assign hour      = time_q.hr;
   assign minute    = time_q.mn;
   assign second    = time_q.sc;
   assign sec_tick  = sec_tick_q;
   assign alarm_irq = irq_q;
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_rtc_alarm_timer.sv
// Directed self-checking bench for rtc_alarm_timer with a 4-cycle second.
module tb_rtc_alarm_timer;

   localparam int unsigned CLK_FREQ   = 4;
   localparam int unsigned NUM_ALARMS = 2;

   logic                  clock;
   logic                  rst_n;
   logic                  w_en_n;
   logic                  r_en_n;
   logic [15:0]           addr;
   logic [7:0]            wdata;
   logic [7:0]            rdata;
   logic [5:0]            hour, minute, second;
   logic                  sec_tick;
   logic [NUM_ALARMS-1:0] alarm_irq;

   int tests;
   int fails;

   rtc_alarm_timer #(.CLK_FREQ(CLK_FREQ), .NUM_ALARMS(NUM_ALARMS)) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .w_en_n    (w_en_n),
      .r_en_n    (r_en_n),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .hour      (hour),
      .minute    (minute),
      .second    (second),
      .sec_tick  (sec_tick),
      .alarm_irq (alarm_irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
      addr   = a;
      wdata  = d;
      w_en_n = 1'b0;
      step();
      w_en_n = 1'b1;
   endtask

   task automatic read_reg(input logic [15:0] a, output logic [7:0] d);
      addr   = a;
      r_en_n = 1'b0;
      step();
      r_en_n = 1'b1;
      d = rdata;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      tests++; if ({hour, minute, second} !== 18'd0) begin fails++; $display("FAIL reset_time: got %0d:%0d:%0d expected 0:0:0", hour, minute, second); end
      tests++; if (sec_tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b expected 0", sec_tick); end
      tests++; if (alarm_irq !== 2'b00) begin fails++; $display("FAIL reset_irq: got %b expected 00", alarm_irq); end
      tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
      rst_n = 1'b1;
   endtask

   task automatic test_count();
      for (int k = 1; k <= 240; k++) begin
         step();
         tests++; if (sec_tick !== ((k % 4) == 0)) begin fails++; $display("FAIL count_tick cycle %0d: got %b expected %b", k, sec_tick, (k % 4) == 0); end
         if (k == 236) begin
            tests++; if ({minute, second} !== {6'd0, 6'd59}) begin fails++; $display("FAIL count_236: got %0d:%0d expected 0:59", minute, second); end
         end
      end
      tests++; if ({hour, minute, second} !== {6'd0, 6'd1, 6'd0}) begin fails++; $display("FAIL count_240: got %0d:%0d:%0d expected 0:1:0", hour, minute, second); end
   endtask

   task automatic test_rollover();
      write_reg(16'h8, 8'd23);
      write_reg(16'h9, 8'd59);
      write_reg(16'hA, 8'd59);
      tests++; if ({hour, minute, second} !== {6'd23, 6'd59, 6'd59}) begin fails++; $display("FAIL roll_set: got %0d:%0d:%0d expected 23:59:59", hour, minute, second); end
      repeat (3) step();
      tests++; if (sec_tick !== 1'b0 || second !== 6'd59) begin fails++; $display("FAIL roll_early: got tick=%b sec=%0d expected tick=0 sec=59", sec_tick, second); end
      step();
      tests++; if ({hour, minute, second} !== 18'd0) begin fails++; $display("FAIL roll_wrap: got %0d:%0d:%0d expected 0:0:0", hour, minute, second); end
      tests++; if (sec_tick !== 1'b1) begin fails++; $display("FAIL roll_tick: got %b expected 1", sec_tick); end
      step();
      tests++; if (sec_tick !== 1'b0) begin fails++; $display("FAIL roll_tick_pulse: got %b expected 0", sec_tick); end
   endtask

   task automatic test_invalid_write();
      logic [7:0] d;
      write_reg(16'h8, 8'd24);
      write_reg(16'h9, 8'd60);
      read_reg(16'h8, d);
      tests++; if (d !== 8'd0) begin fails++; $display("FAIL bad_hour: got %0d expected 0", d); end
      read_reg(16'h9, d);
      tests++; if (d !== 8'd0) begin fails++; $display("FAIL bad_minute: got %0d expected 0", d); end
      write_reg(16'h8, 8'd12);
      read_reg(16'h8, d);
      tests++; if (d !== 8'h0C) begin fails++; $display("FAIL good_hour: got %h expected 0c", d); end
      write_reg(16'h2, 8'd24);
      read_reg(16'h2, d);
      tests++; if (d !== 8'd0) begin fails++; $display("FAIL bad_alarm_hour: got %0d expected 0", d); end
      write_reg(16'h4, 8'd5);
      read_reg(16'h4, d);
      tests++; if (d !== 8'd0) begin fails++; $display("FAIL absent_alarm: got %0d expected 0", d); end
      read_reg(16'hE, d);
      tests++; if (d !== 8'd0) begin fails++; $display("FAIL unmapped_read: got %0d expected 0", d); end
      addr = 16'h8; wdata = 8'd5; w_en_n = 1'b0; r_en_n = 1'b0;
      step();
      w_en_n = 1'b1; r_en_n = 1'b1;
      tests++; if (rdata !== 8'd12) begin fails++; $display("FAIL rw_same_cycle: got %0d expected 12", rdata); end
      tests++; if (hour !== 6'd5) begin fails++; $display("FAIL rw_write: got %0d expected 5", hour); end
   endtask

   task automatic test_alarm();
      logic [7:0] d;
      write_reg(16'h2, 8'd1);
      write_reg(16'h3, 8'd0);
      write_reg(16'hB, 8'h2);
      write_reg(16'h8, 8'd0);
      write_reg(16'h9, 8'd59);
      write_reg(16'hA, 8'd59);
      repeat (4) step();
      tests++; if ({hour, minute, second} !== {6'd1, 6'd0, 6'd0}) begin fails++; $display("FAIL alarm_time: got %0d:%0d:%0d expected 1:0:0", hour, minute, second); end
      tests++; if (alarm_irq !== 2'b00) begin fails++; $display("FAIL alarm_irq_lag: got %b expected 00", alarm_irq); end
      step();
      tests++; if (alarm_irq !== 2'b10) begin fails++; $display("FAIL alarm_irq: got %b expected 10", alarm_irq); end
      write_reg(16'hB, 8'h0);
      step();
      tests++; if (alarm_irq !== 2'b00) begin fails++; $display("FAIL alarm_masked: got %b expected 00", alarm_irq); end
      read_reg(16'hC, d);
      tests++; if (d !== 8'h02) begin fails++; $display("FAIL alarm_status_kept: got %h expected 02", d); end
      write_reg(16'hB, 8'h2);
      write_reg(16'hC, 8'h2);
      step();
      tests++; if (alarm_irq !== 2'b00) begin fails++; $display("FAIL alarm_cleared_irq: got %b expected 00", alarm_irq); end
      read_reg(16'hC, d);
      tests++; if (d !== 8'h00) begin fails++; $display("FAIL alarm_cleared_status: got %h expected 00", d); end
      write_reg(16'h8, 8'd1);
      write_reg(16'h9, 8'd0);
      write_reg(16'hA, 8'd0);
      step();
      read_reg(16'hC, d);
      tests++; if (d !== 8'h00) begin fails++; $display("FAIL alarm_direct_set: got %h expected 00", d); end
   endtask

   task automatic test_clear_set_collision();
      logic [7:0] d;
      write_reg(16'h0, 8'd2);
      write_reg(16'h1, 8'd0);
      write_reg(16'hB, 8'h1);
      write_reg(16'h8, 8'd1);
      write_reg(16'h9, 8'd59);
      write_reg(16'hA, 8'd59);
      repeat (3) step();
      write_reg(16'hC, 8'h1);
      tests++; if (hour !== 6'd2 || sec_tick !== 1'b1) begin fails++; $display("FAIL collide_tick: got hour=%0d tick=%b expected hour=2 tick=1", hour, sec_tick); end
      read_reg(16'hC, d);
      tests++; if (d !== 8'h01) begin fails++; $display("FAIL collide_set_wins: got %h expected 01", d); end
      write_reg(16'hC, 8'h1);
      write_reg(16'hB, 8'h0);
      read_reg(16'hC, d);
      tests++; if (d !== 8'h00) begin fails++; $display("FAIL collide_clear: got %h expected 00", d); end
   endtask

   task automatic test_tick_write();
      write_reg(16'h9, 8'd5);
      write_reg(16'hA, 8'd59);
      repeat (3) step();
      write_reg(16'hA, 8'd30);
      tests++; if ({minute, second} !== {6'd5, 6'd30}) begin fails++; $display("FAIL tickwr_value: got %0d:%0d expected 5:30", minute, second); end
      tests++; if (sec_tick !== 1'b1) begin fails++; $display("FAIL tickwr_pulse: got %b expected 1", sec_tick); end
      repeat (3) step();
      tests++; if (second !== 6'd30 || sec_tick !== 1'b0) begin fails++; $display("FAIL tickwr_hold: got sec=%0d tick=%b expected sec=30 tick=0", second, sec_tick); end
      step();
      tests++; if ({minute, second} !== {6'd5, 6'd31} || sec_tick !== 1'b1) begin fails++; $display("FAIL tickwr_next: got %0d:%0d tick=%b expected 5:31 tick=1", minute, second, sec_tick); end
   endtask

   task automatic test_run_stop_and_reset();
      logic [7:0] d;
      write_reg(16'hA, 8'd10);
      step();
      write_reg(16'hD, 8'h0);
      for (int k = 0; k < 20; k++) begin
         step();
         tests++; if (sec_tick !== 1'b0) begin fails++; $display("FAIL stop_tick cycle %0d: got %b expected 0", k, sec_tick); end
      end
      tests++; if (second !== 6'd10) begin fails++; $display("FAIL stop_frozen: got %0d expected 10", second); end
      write_reg(16'hD, 8'h1);
      step();
      tests++; if (second !== 6'd10) begin fails++; $display("FAIL resume_hold: got %0d expected 10", second); end
      step();
      tests++; if (second !== 6'd11 || sec_tick !== 1'b1) begin fails++; $display("FAIL resume_tick: got sec=%0d tick=%b expected sec=11 tick=1", second, sec_tick); end
      read_reg(16'hD, d);
      tests++; if (d !== 8'h01) begin fails++; $display("FAIL ctrl_read: got %h expected 01", d); end
      rst_n = 1'b0;
      #1;
      tests++; if ({hour, minute, second} !== 18'd0 || rdata !== 8'h00 || sec_tick !== 1'b0 || alarm_irq !== 2'b00) begin
         fails++; $display("FAIL midreset: got %0d:%0d:%0d rdata=%h tick=%b irq=%b expected all zero", hour, minute, second, rdata, sec_tick, alarm_irq);
      end
      repeat (2) step();
      rst_n = 1'b1;
      repeat (3) step();
      tests++; if (second !== 6'd0 || sec_tick !== 1'b0) begin fails++; $display("FAIL midreset_partial: got sec=%0d tick=%b expected sec=0 tick=0", second, sec_tick); end
      step();
      tests++; if (second !== 6'd1 || sec_tick !== 1'b1) begin fails++; $display("FAIL midreset_first: got sec=%0d tick=%b expected sec=1 tick=1", second, sec_tick); end
   endtask

   initial begin
      tests  = 0;
      fails  = 0;
      rst_n  = 1'b0;
      w_en_n = 1'b1;
      r_en_n = 1'b1;
      addr   = '0;
      wdata  = '0;
      test_reset();
      test_count();
      test_rollover();
      test_invalid_write();
      test_alarm();
      test_clear_set_collision();
      test_tick_write();
      test_run_stop_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
